bcd_serial_add_ctrl: RTL

- Sequencer that performs NUM_DIGITS-digit packed-BCD addition by time-multiplexing one existing 2-digit (8-bit) BCD adder slice, least-significant digit pair first.
- Carry is chained through a register between slices.
- Valid/ready handshake on both sides.
- Input digits are screened for non-BCD codes; such operands are rejected with an error flag.

---
 rtl/bcd_ctrl_pkg.sv | 19 +
 rtl/bcd_serial_add_ctrl_slice.sv | 41 ++++
 rtl/bcd_serial_add_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcd_ctrl_pkg.sv
// Shared types, constants and helpers for the serial BCD adder controller.
package bcd_ctrl_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned PAIR_W  = 8;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // True when the nibble encodes a legal decimal digit (0..9).
   function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] nibble);
      return (nibble <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_slice.sv
// Two-digit (8-bit) packed-BCD adder slice, purely combinational.
// Ports: A, B   - two BCD digits each, low digit in [3:0]
//        Cin    - carry into the low digit
//        S      - two-digit BCD sum
//        Cout   - decimal carry out of the high digit
module bcd_add2_slice
   import bcd_ctrl_pkg::*;
(
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   output logic [7:0] S,
   output logic       Cout
);

   logic [4:0] t_lo;
   logic [4:0] t_hi;
   logic       c_lo;

   // Binary add per digit, then +6 correction when the digit overflows 9.
   always_comb begin
      t_lo = 5'(A[3:0]) + 5'(B[3:0]) + 5'(Cin);
      S    = '0;
      c_lo = 1'b0;
      Cout = 1'b0;
      if (t_lo > 5'd9) begin
         S[3:0] = 4'(t_lo + 5'd6);
         c_lo   = 1'b1;
      end else begin
         S[3:0] = t_lo[3:0];
      end
      t_hi = 5'(A[7:4]) + 5'(B[7:4]) + 5'(c_lo);
      if (t_hi > 5'd9) begin
         S[7:4] = 4'(t_hi + 5'd6);
         Cout   = 1'b1;
      end else begin
         S[7:4] = t_hi[3:0];
      end
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial NUM_DIGITS-digit packed-BCD adder: one 2-digit slice reused per pair,
// least-significant pair first, carry chained through a register.
// Ports: clk, rst_n                     - clock, async active-low reset
//        in_valid/in_ready, in_a, in_b, in_cin - operand handshake
//        out_valid/out_ready, out_sum, out_cout, out_err - result handshake
//        busy                          - high while RUN or DONE
module bcd_serial_add_ctrl
   import bcd_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [4*NUM_DIGITS-1:0]   in_a,
   input  logic [4*NUM_DIGITS-1:0]   in_b,
   input  logic                      in_cin,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [4*NUM_DIGITS-1:0]   out_sum,
   output logic                      out_cout,
   output logic                      out_err,
   output logic                      busy
);

   localparam int unsigned PAIRS = NUM_DIGITS / 2;
   localparam int unsigned W     = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

   state_e             state_q, state_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               cout_q, cout_d, err_q, err_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic               any_bad;
   logic [PAIR_W-1:0]  slice_s;
   logic               slice_cout;

   bcd_add2_slice u_slice (
      .A    (a_q[PAIR_W-1:0]),
      .B    (b_q[PAIR_W-1:0]),
      .Cin  (carry_q),
      .S    (slice_s),
      .Cout (slice_cout)
   );

   // Flag any non-decimal nibble in either operand.
   always_comb begin
      any_bad = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (!is_bcd_digit(in_a[i*DIGIT_W +: DIGIT_W]) ||
             !is_bcd_digit(in_b[i*DIGIT_W +: DIGIT_W]))
            any_bad = 1'b1;
      end
   end

   // Next-state and datapath.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      cout_d  = cout_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               err_d   = any_bad;
               state_d = any_bad ? DONE : RUN;
            end
         end
         RUN: begin
            // New pair enters at the top; after PAIRS steps the word is complete.
            sum_d   = (sum_q >> PAIR_W) | (W'(slice_s) << (W - PAIR_W));
            carry_d = slice_cout;
            a_d     = a_q >> PAIR_W;
            b_d     = b_q >> PAIR_W;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(PAIRS - 1)) begin
               cout_d  = slice_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         cout_q      <= 1'b0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         cout_q      <= cout_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_err   = err_q;
   assign busy      = busy_q;

endmodule
